// File: rtl/multicycle_control_unit_p.sv
//==============================================================================
// Module   : multicycle_control_unit_p
// Purpose  : Multicycle CPU control FSM with handshake memory timeout and trap.
//            Optional performance counters are enabled by CTRL_PERF_CNT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_control_unit_p #(
  parameter int OPW         = 5,
  parameter int ALUW        = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int SP_STEP     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            cond_nz,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCSrc,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic [1:0]      RegDst,
  output logic            MemToReg,
  output logic            mem_req,
  output logic            mem_we,
  output logic [1:0]      AddrSel,
  output logic            ALUSrc,
  output logic            ExtSel,
  output logic [ALUW-1:0] ALUCtrl,
  output logic [7:0]      sp_step,
  output logic            retire,
  output logic            trap,
  output logic [3:0]      state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  localparam int OP_ADD  = 0;
  localparam int OP_SRA  = 5;
  localparam int OP_ADDI = 6;
  localparam int OP_NORI = 9;
  localparam int OP_LUI  = 10;
  localparam int OP_CMOV = 11;
  localparam int OP_JMP  = 12;
  localparam int OP_JAL  = 13;
  localparam int OP_LD   = 14;
  localparam int OP_ST   = 15;
  localparam int OP_PUSH = 16;
  localparam int OP_POP  = 17;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_WB_RI   = 4'd3,
    S_MEM_RD  = 4'd4,
    S_WB_LD   = 4'd5,
    S_MEM_WR  = 4'd6,
    S_STK_WR  = 4'd7,
    S_STK_DEC = 4'd8,
    S_STK_RD  = 4'd9,
    S_POP_WB  = 4'd10,
    S_STK_INC = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait_cnt;
  logic        w_alu_r;
  logic        w_alu_i;
  logic        w_is_lui;
  logic        w_is_cmov;
  logic        w_is_jal;
  logic        w_mem_state;
  logic        w_timeout;
  logic [2:0]  w_alu_code;

  assign w_alu_r   = (opcode >= OPW'(OP_ADD)) && (opcode <= OPW'(OP_SRA));
  assign w_alu_i   = (opcode >= OPW'(OP_ADDI)) && (opcode <= OPW'(OP_NORI));
  assign w_is_lui  = (opcode == OPW'(OP_LUI));
  assign w_is_cmov = (opcode == OPW'(OP_CMOV));
  assign w_is_jal  = (opcode == OPW'(OP_JAL));

  // R-type opcodes map straight onto ALU codes; immediates reuse add/sub/nand/nor.
  always_comb begin
    w_alu_code = 3'b000;
    if (w_alu_r)
      w_alu_code = 3'(opcode - OPW'(OP_ADD));
    else if (w_alu_i)
      w_alu_code = 3'(opcode - OPW'(OP_ADDI));
    else if (w_is_lui || w_is_cmov)
      w_alu_code = 3'b110;
  end

  assign w_mem_state = (r_state == S_FETCH)  || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR) || (r_state == S_STK_WR) ||
                       (r_state == S_STK_RD);
  // Timeout fires on the MEM_TIMEOUT-th consecutive wait cycle; a ready wins.
  assign w_timeout   = w_mem_state && !mem_ready &&
                       (r_wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OPW'(OP_JMP) || w_is_jal) w_next = S_JUMP;
        else if (opcode == OPW'(OP_LD))         w_next = S_MEM_RD;
        else if (opcode == OPW'(OP_ST))         w_next = S_MEM_WR;
        else if (opcode == OPW'(OP_PUSH))       w_next = S_STK_WR;
        else if (opcode == OPW'(OP_POP))        w_next = S_STK_RD;
        else if (w_alu_r || w_alu_i || w_is_lui || w_is_cmov)
                                                w_next = S_EXEC;
        else                                    w_next = S_TRAP;
      end
      S_EXEC:    w_next = S_WB_RI;
      S_WB_RI:   w_next = S_FETCH;
      S_MEM_RD:  if (mem_ready) w_next = S_WB_LD;
      S_WB_LD:   w_next = S_FETCH;
      S_MEM_WR:  if (mem_ready) w_next = S_FETCH;
      S_STK_WR:  if (mem_ready) w_next = S_STK_DEC;
      S_STK_DEC: w_next = S_FETCH;
      S_STK_RD:  if (mem_ready) w_next = S_POP_WB;
      S_POP_WB:  w_next = S_STK_INC;
      S_STK_INC: w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_TRAP;
    endcase
    if (w_timeout)
      w_next = S_TRAP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= 8'd0;
      else if (w_mem_state && !mem_ready)
        r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign state   = r_state;
  assign sp_step = 8'(SP_STEP);

  // Every strobe is held low while reset is asserted, abandoning any request.
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 2'b00;
    MemToReg = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    AddrSel  = 2'b00;
    ALUSrc   = 1'b0;
    ExtSel   = 1'b0;
    ALUCtrl  = '0;
    retire   = 1'b0;
    trap     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_EXEC: begin
          ALUCtrl = ALUW'(w_alu_code);
          ALUSrc  = w_alu_i || w_is_lui;
          ExtSel  = w_is_lui;
        end
        S_WB_RI: begin
          RegWrite = w_is_cmov ? cond_nz : 1'b1;
          retire   = 1'b1;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          AddrSel = 2'b01;
        end
        S_STK_RD: begin
          mem_req = 1'b1;
          AddrSel = 2'b10;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          AddrSel = 2'b01;
          retire  = mem_ready;
        end
        S_STK_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          AddrSel = 2'b10;
        end
        S_WB_LD: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          retire   = 1'b1;
        end
        S_POP_WB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        S_STK_DEC, S_STK_INC: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
          ALUSrc   = 1'b1;
          ALUCtrl  = (r_state == S_STK_DEC) ? ALUW'(3'b001) : ALUW'(3'b000);
          retire   = 1'b1;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSrc    = 1'b1;
          retire   = 1'b1;
          RegWrite = w_is_jal;
          RegDst   = w_is_jal ? 2'b10 : 2'b00;
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      if (r_state != S_TRAP)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit_p.sv
//==============================================================================
// Module   : tb_multicycle_control_unit_p
// Purpose  : Directed self-checking bench for multicycle_control_unit_p.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multicycle_control_unit_p;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic       cond_nz;
  logic       mem_ready;
  logic       PCWrite, PCSrc, IRWrite, RegWrite, MemToReg;
  logic       mem_req, mem_we, ALUSrc, ExtSel, retire, trap;
  logic [1:0] RegDst, AddrSel;
  logic [2:0] ALUCtrl;
  logic [7:0] sp_step;
  logic [3:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n_retire = 0;
  int r0;

  multicycle_control_unit_p dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cond_nz(cond_nz),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .mem_req(mem_req), .mem_we(mem_we),
    .AddrSel(AddrSel), .ALUSrc(ALUSrc), .ExtSel(ExtSel),
    .ALUCtrl(ALUCtrl), .sp_step(sp_step), .retire(retire),
    .trap(trap), .state(state)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, tallying retire pulses seen in the cycle being left.
  task automatic tick();
    if (retire === 1'b1) n_retire++;
    @(posedge clk);
    #2;
  endtask

  task automatic do_exec(input logic [4:0] op, input logic [2:0] alu,
                         input logic src, input logic ext);
    opcode = op;
    tick();
    tick();
    chk("exec_state", state, 2);
    chk("exec_aluctrl", ALUCtrl, alu);
    chk("exec_alusrc", ALUSrc, src);
    chk("exec_extsel", ExtSel, ext);
    tick();
    chk("exec_wb_retire", retire, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = 5'd0; cond_nz = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_trap", trap, 0);
    chk("sp_step", sp_step, 1);

    // ADD walk-through
    reset = 1'b0; #1;
    chk("fetch_req", mem_req, 1);
    chk("fetch_irwrite", IRWrite, 1);
    chk("fetch_pcsrc", PCSrc, 0);
    tick(); chk("add_s1", state, 1); chk("add_s1_ret", retire, 0);
    tick(); chk("add_s2", state, 2); chk("add_alu", ALUCtrl, 0); chk("add_s2_ret", retire, 0);
    tick(); chk("add_s3", state, 3); chk("add_regwr", RegWrite, 1); chk("add_ret", retire, 1);
    tick(); chk("add_s0", state, 0); chk("add_s0_ret", retire, 0);

    do_exec(5'd1,  3'b001, 1'b0, 1'b0);
    do_exec(5'd5,  3'b101, 1'b0, 1'b0);
    do_exec(5'd9,  3'b011, 1'b1, 1'b0);
    do_exec(5'd10, 3'b110, 1'b1, 1'b1);

    // LD with three wait cycles in MEM_RD
    opcode = 5'd14;
    tick(); tick();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait_state", state, 4);
      chk("ld_wait_req", mem_req, 1);
      chk("ld_addrsel", AddrSel, 1);
      chk("ld_we", mem_we, 0);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("ld_req4", mem_req, 1);
    tick();
    chk("ld_wb_state", state, 5);
    chk("ld_wb_regwr", RegWrite, 1);
    chk("ld_wb_m2r", MemToReg, 1);
    chk("ld_wb_ret", retire, 1);
    chk("ld_trap", trap, 0);
    tick();

    // PUSH then POP
    r0 = n_retire;
    opcode = 5'd16;
    tick(); tick();
    chk("push_s7", state, 7); chk("push_we", mem_we, 1); chk("push_addr", AddrSel, 2);
    tick();
    chk("push_s8", state, 8); chk("push_alu", ALUCtrl, 1);
    chk("push_dst", RegDst, 1); chk("push_src", ALUSrc, 1); chk("push_regwr", RegWrite, 1);
    tick();
    opcode = 5'd17;
    tick(); tick();
    chk("pop_s9", state, 9); chk("pop_addr", AddrSel, 2); chk("pop_we", mem_we, 0);
    tick();
    chk("pop_s10", state, 10); chk("pop_m2r", MemToReg, 1); chk("pop_s10_ret", retire, 0);
    tick();
    chk("pop_s11", state, 11); chk("pop_alu", ALUCtrl, 0); chk("pop_dst", RegDst, 1);
    tick();
    chk("stack_retires", n_retire - r0, 2);

    // ST retires in MEM_WR on ready
    opcode = 5'd15;
    tick(); tick();
    chk("st_s6", state, 6); chk("st_we", mem_we, 1); chk("st_addr", AddrSel, 1);
    chk("st_ret", retire, 1);
    tick();
    chk("st_back", state, 0);

    // CMOV both conditions, then JAL and JUMP
    opcode = 5'd11; cond_nz = 1'b0;
    tick(); tick();
    chk("cmov_alu", ALUCtrl, 6); chk("cmov_src", ALUSrc, 0);
    tick();
    chk("cmov0_regwr", RegWrite, 0); chk("cmov0_ret", retire, 1);
    tick();
    cond_nz = 1'b1;
    tick(); tick(); tick();
    chk("cmov1_regwr", RegWrite, 1);
    tick();
    opcode = 5'd13;
    tick(); tick();
    chk("jal_s12", state, 12); chk("jal_pcsrc", PCSrc, 1); chk("jal_pcwr", PCWrite, 1);
    chk("jal_dst", RegDst, 2); chk("jal_regwr", RegWrite, 1);
    tick();
    opcode = 5'd12;
    tick(); tick();
    chk("jmp_pcsrc", PCSrc, 1); chk("jmp_regwr", RegWrite, 0);
    tick();

    // Ready on the last permitted wait cycle beats the timeout
    opcode = 5'd0; mem_ready = 1'b0; #1;
    repeat (14) tick();
    chk("prio_state", state, 0);
    mem_ready = 1'b1; #1;
    tick();
    chk("prio_decode", state, 1);
    tick(); tick(); tick();

    // Wait counter clears between FETCH and MEM_RD
    opcode = 5'd14; mem_ready = 1'b0; #1;
    repeat (10) tick();
    mem_ready = 1'b1; #1;
    tick(); tick();
    mem_ready = 1'b0; #1;
    repeat (10) tick();
    chk("clr_state", state, 4);
    mem_ready = 1'b1; #1;
    tick();
    chk("clr_wb", state, 5); chk("clr_trap", trap, 0);
    tick();

    // FETCH timeout
    mem_ready = 1'b0; #1;
    repeat (14) tick();
    chk("to_pre", state, 0);
    tick();
    chk("to_state", state, 13); chk("to_trap", trap, 1); chk("to_req", mem_req, 0);

    // Illegal opcodes
    reset = 1'b1; tick();
    reset = 1'b0; mem_ready = 1'b1; opcode = 5'd31; #1;
    tick(); tick();
    chk("ill31_state", state, 13); chk("ill31_trap", trap, 1);
    repeat (20) tick();
    chk("ill_sticky_state", state, 13); chk("ill_sticky_trap", trap, 1);
    chk("ill_pcwr", PCWrite, 0);
    reset = 1'b1; #1;
    chk("ill_rst_trap", trap, 0);
    tick();
    reset = 1'b0; opcode = 5'd18; #1;
    chk("ill_rst_state", state, 0);
    tick(); tick();
    chk("ill18_state", state, 13);
    reset = 1'b1; tick(); reset = 1'b0; #1;

    // Reset mid-wait abandons the request
    opcode = 5'd14;
    tick(); tick();
    mem_ready = 1'b0; #1;
    tick(); tick(); tick();
    reset = 1'b1; #1;
    chk("midrst_req", mem_req, 0); chk("midrst_addr", AddrSel, 0);
    chk("midrst_regwr", RegWrite, 0); chk("midrst_ret", retire, 0);
    tick();
    chk("midrst_state", state, 0); chk("midrst_req2", mem_req, 0);
    reset = 1'b0; #1;
    chk("midrst_fetch_req", mem_req, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit_p.md
Name: multicycle_control_unit_p

Overview:
Parametrised successor to the team's multicycle CPU controller FSM. It decodes the same ISA (ALU, immediate, jump/JAL, LD/ST, PUSH/POP) and adds LUI, conditional CMOV and an illegal-opcode trap. Memory access uses a variable-latency request/ready handshake with a timeout, and a one-cycle retire pulse marks each completed instruction. The block sits between the instruction register and the datapath muxes, register file and memory port.

Parameters:
OPW, 5, opcode width; must be at least 5; legal opcodes are 0..17 zero-extended, all other values are illegal.
ALUW, 3, ALUCtrl width; must be at least 3; codes are zero-extended.
MEM_TIMEOUT, 15, maximum wait cycles for mem_ready before trap; range 1..255.
SP_STEP, 1, stack increment/decrement amount, driven on sp_step.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
opcode  in  OPW  opcode from the instruction register
cond_nz  in  1  CMOV condition: rt != 0
mem_ready  in  1  memory has completed the current request
PCWrite  out  1  PC load strobe
PCSrc  out  1  0 = PC+1, 1 = jump target
IRWrite  out  1  latch instruction from memory
RegWrite  out  1  register-file write strobe
RegDst  out  2  destination: 00 = rd, 01 = SP, 10 = link register
MemToReg  out  1  write-back data from memory
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  request is a write (valid with mem_req)
AddrSel  out  2  address: 00 = PC, 01 = ALU result, 10 = SP
ALUSrc  out  1  ALU B operand: 0 = register, 1 = immediate/step
ExtSel  out  1  0 = sign-extend, 1 = upper (LUI)
ALUCtrl  out  ALUW  000 add, 001 sub, 010 nand, 011 nor, 100 srl, 101 sra, 110 pass-B
sp_step  out  8  constant SP_STEP
retire  out  1  one-cycle pulse on the last cycle of an instruction
trap  out  1  sticky; set on illegal opcode or memory timeout
state  out  4  current state encoding

Behaviour:
- State register and wait counter are synchronous. When reset is sampled high: state = FETCH(0), wait_cnt = 0, trap = 0. While reset is high, every output strobe is forced to 0 (mem_req included). Reset takes effect mid-operation, including an outstanding request; that request is abandoned.
- Outputs are combinational from state, opcode, mem_ready and cond_nz. Unlisted outputs default to 0.
- State encodings: FETCH 0, DECODE 1, EXEC 2, WB_RI 3, MEM_RD 4, WB_LD 5, MEM_WR 6, STK_WR 7, STK_DEC 8, STK_RD 9, POP_WB 10, STK_INC 11, JUMP 12, TRAP 13.
- FETCH: mem_req = 1, AddrSel = 00. When mem_ready: IRWrite = 1, PCWrite = 1, PCSrc = 0, go to DECODE. Otherwise stay.
- DECODE transitions:
  - JUMP/JAL -> JUMP.
  - LD -> MEM_RD.
  - ST -> MEM_WR.
  - PUSH -> STK_WR.
  - POP -> STK_RD.
  - ALU, immediate, LUI, CMOV -> EXEC.
  - Any other opcode -> TRAP.
- EXEC (1 cycle) drives ALUCtrl and ALUSrc per opcode:
  - ADDI/SUBI/NANDI/NORI: ALUSrc = 1, ExtSel = 0.
  - LUI: ALUCtrl = 110, ALUSrc = 1, ExtSel = 1.
  - CMOV: ALUCtrl = 110, ALUSrc = 0.
  - Next state is WB_RI.
- WB_RI: RegWrite = 1, RegDst = 00. For CMOV, RegWrite = cond_nz. retire = 1. Next state is FETCH.
- MEM_RD and STK_RD: mem_req = 1, mem_we = 0. AddrSel = 01 (MEM_RD) or 10 (STK_RD). Advance to WB_LD / POP_WB on mem_ready.
- MEM_WR and STK_WR: mem_req = 1, mem_we = 1. AddrSel = 01 or 10. Advance on mem_ready:
  - MEM_WR -> FETCH, with retire = 1 in that cycle.
  - STK_WR -> STK_DEC.
- WB_LD: RegWrite = 1, MemToReg = 1, retire = 1. Next state is FETCH.
- POP_WB: RegWrite = 1, MemToReg = 1. Next state is STK_INC.
- STK_DEC: RegWrite = 1, RegDst = 01, ALUSrc = 1, ALUCtrl = 001, retire = 1. Next state is FETCH.
- STK_INC: same as STK_DEC but ALUCtrl = 000. Next state is FETCH.
- JUMP: PCWrite = 1, PCSrc = 1, retire = 1. For JAL also RegWrite = 1, RegDst = 10. Next state is FETCH.
- Wait counter: increments each cycle that mem_req = 1 and mem_ready = 0, and clears whenever the state changes. If it reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP. mem_ready in the same cycle takes priority over the timeout.
- TRAP: all strobes 0, trap = 1. Only reset leaves TRAP.
- Unused state encodings (14, 15) go to TRAP.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - cycle_cnt [31:0]: increments every non-reset cycle outside TRAP.
  - instr_cnt [31:0]: increments on each retire.
  - Both clear on reset and wrap modulo 2^32.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
1. Reset, then ADD with mem_ready tied to 1 -> states 0,1,2,3,0; retire high only in state 3; ALUCtrl = 000.
2. LD with mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles at AddrSel = 01; then WB_LD with RegWrite = 1, MemToReg = 1; no trap.
3. PUSH then POP -> push path 7,8 with ALUCtrl 001 and RegDst 01; pop path 9,10,11 with ALUCtrl 000; retire asserted exactly twice in total.
4. CMOV with cond_nz = 0, then with cond_nz = 1 -> RegWrite = 0, then RegWrite = 1 in WB_RI; JAL -> PCSrc = 1 and RegDst = 10 in state 12.
5. opcode = 5'b11111 -> TRAP (13) after DECODE; trap stays 1 for 20 cycles; reset returns state to 0 and trap to 0.
6. mem_ready held 0 in FETCH with MEM_TIMEOUT = 15 -> TRAP after 15 wait cycles. Separately, assert reset mid-wait -> state 0 next cycle and all outputs 0 while reset is high.
